// File: rtl/l1_miss_ctrl.sv
// Miss-handling sequencer for one 4-way L1 set: lookup, dirty writeback, line refill, LRU update.
// One request in flight; strobes are decoded from the state so async reset drops them at once.
module l1_miss_ctrl #(
    parameter int INDEX_W = 6,
    parameter int WAY_W   = 2,
    parameter int BEATS   = 4,
    localparam int BW     = $clog2(BEATS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [INDEX_W-1:0] req_index_i,
    output logic               resp_valid_o,
    output logic [WAY_W-1:0]   resp_way_o,
    input  logic               hit_i,
    input  logic [WAY_W-1:0]   hit_way_i,
    input  logic               victim_dirty_i,
    input  logic [WAY_W-1:0]   lru_victim_i,
    output logic               lru_valid_o,
    output logic [INDEX_W-1:0] lru_index_o,
    output logic [WAY_W-1:0]   lru_way_o,
    output logic [WAY_W-1:0]   arr_way_o,
    output logic [BW-1:0]      arr_beat_o,
    output logic               arr_we_o,
    output logic               tag_we_o,
    output logic               mem_wr_valid_o,
    output logic               mem_wr_last_o,
    input  logic               mem_wr_ready_i,
    output logic               mem_rd_req_o,
    input  logic               mem_rd_gnt_i,
    input  logic               mem_rd_valid_i
);
    typedef enum logic [2:0] {IDLE, LOOKUP, WB, RD_REQ, REFILL, FILL_DONE} state_t;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    state_t             r_state, w_next;
    logic [BW-1:0]      r_beat;
    logic [INDEX_W-1:0] r_index;
    logic [WAY_W-1:0]   r_victim;
    logic               w_beat_last;
    logic               w_beat_adv;

    assign w_beat_last = (r_beat == LAST_BEAT);
    assign w_beat_adv  = (r_state == WB     && mem_wr_ready_i) ||
                         (r_state == REFILL && mem_rd_valid_i);

    // Latched index keeps the LRU block pointed at this set for the whole miss.
    assign lru_index_o = r_index;
    assign arr_way_o   = r_victim;
    assign arr_beat_o  = r_beat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_index  <= '0;
            r_victim <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid_i)
                r_index <= req_index_i;
            if (r_state == LOOKUP && !hit_i)
                r_victim <= lru_victim_i;
            if (w_beat_adv)
                r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
        end
    end

    always_comb begin
        w_next         = r_state;
        req_ready_o    = 1'b0;
        resp_valid_o   = 1'b0;
        resp_way_o     = '0;
        lru_valid_o    = 1'b0;
        lru_way_o      = '0;
        arr_we_o       = 1'b0;
        tag_we_o       = 1'b0;
        mem_wr_valid_o = 1'b0;
        mem_wr_last_o  = 1'b0;
        mem_rd_req_o   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) w_next = LOOKUP;
            end
            LOOKUP: begin
                if (hit_i) begin
                    resp_valid_o = 1'b1;
                    resp_way_o   = hit_way_i;
                    lru_valid_o  = 1'b1;
                    lru_way_o    = hit_way_i;
                    w_next       = IDLE;
                end else begin
                    w_next = victim_dirty_i ? WB : RD_REQ;
                end
            end
            WB: begin
                mem_wr_valid_o = 1'b1;
                mem_wr_last_o  = w_beat_last;
                if (mem_wr_ready_i && w_beat_last) w_next = RD_REQ;
            end
            RD_REQ: begin
                mem_rd_req_o = 1'b1;
                if (mem_rd_gnt_i) w_next = REFILL;
            end
            REFILL: begin
                arr_we_o = mem_rd_valid_i;
                if (mem_rd_valid_i && w_beat_last) w_next = FILL_DONE;
            end
            FILL_DONE: begin
                tag_we_o     = 1'b1;
                resp_valid_o = 1'b1;
                resp_way_o   = r_victim;
                lru_valid_o  = 1'b1;
                lru_way_o    = r_victim;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule
